spi_receptor: RTL and testbench
===============================

// Module: spi_receptor
// PURPOSE
//  SPI slave that sits directly downstream of the team's SPI master transmitter: it consumes SCK/CS/MOSI
//  and returns MISO. Oversamples the SPI pins on the system clock, supports all four CKP/CPH modes and
//  exchanges one DATA_W-bit word per CS frame, MSB first. Presents the received word to local logic.
// PARAMETERS
//  DATA_W       16  frame length in bits (must match the master's shift register)
//  SYNC_STAGES  2   flip-flop stages in each pin synchronizer (>=2)
// PORTS
//  CLK       in   1       system clock; SCK period must be >= 4 CLK periods
//  RESET     in   1       asynchronous, active-low reset
//  CKP       in   1       clock polarity (SCK idle level)
//  CPH       in   1       clock phase (0: sample on leading edge, 1: sample on trailing edge)
//  SCK       in   1       SPI clock from master (asynchronous to CLK)
//  CS        in   1       chip select from master, active low
//  MOSI      in   1       serial data from master
//  MISO      out  1       serial data to master
//  TX_DATA   in   DATA_W  word to return to master; captured at CS falling edge
//  RX_DATA   out  DATA_W  last complete word received
//  RX_VALID  out  1       one-CLK pulse when RX_DATA updates
//  BUSY      out  1       high while a frame is in progress (ACTIVE or DONE)
//  FRAME_ERR out  1       one-CLK pulse when CS rises before DATA_W bits are sampled
// BEHAVIOUR
//  - Reset (RESET=0, async): MISO=0, RX_DATA=0, RX_VALID=0, BUSY=0, FRAME_ERR=0, state=IDLE, bit_cnt=0.
//  - SCK, CS, MOSI pass through SYNC_STAGES synchronizers. Edge detect runs on the synchronized SCK.
//    Leading edge = SCK leaves CKP level; trailing edge = SCK returns to CKP level.
//  - CKP/CPH are latched at CS falling edge and held for the frame. Mid-frame changes are ignored.
//  - FSM:
//    IDLE   -> ACTIVE on sync CS falling: load tx_sh<=TX_DATA, bit_cnt<=0.
//              CPH=0: MISO<=TX_DATA[MSB] immediately.
//    ACTIVE -> on sample edge: rx_sh<={rx_sh[DATA_W-2:0],MOSI_sync}, bit_cnt++.
//              on shift edge: MISO<=next tx_sh bit. CPH=1: first leading edge drives the MSB.
//              CPH=0: the shift edge after the last sample drives no new bit (MISO holds).
//    ACTIVE -> DONE when bit_cnt reaches DATA_W: RX_DATA<=rx_sh, RX_VALID=1 for one cycle.
//    DONE   -> IDLE on sync CS rising. Further SCK edges in DONE are ignored (no extra shifting).
//    ACTIVE -> IDLE on sync CS rising with bit_cnt<DATA_W: FRAME_ERR pulse, RX_DATA unchanged,
//              no RX_VALID.
//  - MISO is driven 0 whenever state=IDLE (no tristate, single driver).
//  - Latency: RX_VALID rises SYNC_STAGES+1 CLK cycles after the final sampling SCK edge at the pin.
//  - bit_cnt is $clog2(DATA_W+1) bits wide and never wraps. Counting saturates at DATA_W.
//  - Simultaneous sync CS rise and final sample edge: the sample completes, RX_VALID fires,
//    no FRAME_ERR, and the FSM goes to IDLE.
//  - CS falls again within the same cycle that IDLE is entered: a new frame starts on the next cycle.
//  - Async reset mid-frame aborts immediately. No RX_VALID or FRAME_ERR is produced.
// STRUCTURE
//  - Shared package spi_pkg: state encodings (IDLE/ACTIVE/DONE), mode constants MODO0..MODO3 = {CKP,CPH},
//    and the default DATA_W. The master and this block both use it.
//  - One sub-module, spi_sync (SYNC_STAGES-deep synchronizer with async active-low reset), instantiated
//    for SCK, CS and MOSI. The reset value of the CS synchronizer is 1.
// TESTING
//  - Mode 0: TX_DATA=16'h3C5A, master sends 16'hA5C3 -> RX_DATA=16'hA5C3, one RX_VALID, master gets 16'h3C5A.
//  - Modes 1, 2, 3 in turn with the same words -> identical RX_DATA/MISO results. SCK idle level = CKP.
//  - CS raised after 9 bits -> FRAME_ERR pulse, no RX_VALID, RX_DATA keeps the previous value (16'hA5C3).
//  - 18 SCK cycles in one frame (mode 0, 16'hFFFF) -> RX_DATA=16'hFFFF, extra edges ignored, single RX_VALID.
//  - RESET pulsed low after 8 bits -> all outputs 0 at once. The next full frame 16'h0001 is received correctly.
//  - Back-to-back frames 16'h1234, 16'hBEEF with CS high for 2 CLK -> two RX_VALID pulses, values in order.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, mode constants
// and the default frame length used by master and slave.
package spi_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_state_t;

    // Mode encoding is {CKP, CPH}
    localparam logic [1:0] MODO0 = 2'b00;
    localparam logic [1:0] MODO1 = 2'b01;
    localparam logic [1:0] MODO2 = 2'b10;
    localparam logic [1:0] MODO3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous pin,
// with a selectable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the pin value through the synchronizer chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_receptor.sv
// SPI slave: oversamples SCK/CS/MOSI on CLK, supports all four
// CKP/CPH modes, exchanges one DATA_W-bit word per CS frame.
module spi_receptor
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int SW = DATA_W - 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic sck_s, cs_s, mosi_s;
    logic sck_prev_q, cs_prev_q;

    spi_state_t        state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]     rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              miso_q, miso_d;
    logic              ckp_q, ckp_d;
    logic              cph_q, cph_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    logic cs_fall, cs_rise;
    logic sck_edge, lead_edge, trail_edge;
    logic sample_edge, shift_edge, last_sample;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i (CLK), .rst_ni(RESET), .d_i(SCK), .q_o(sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i (CLK), .rst_ni(RESET), .d_i(CS), .q_o(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i (CLK), .rst_ni(RESET), .d_i(MOSI), .q_o(mosi_s)
    );

    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign sck_edge    = sck_s ^ sck_prev_q;
    assign lead_edge   = sck_edge & (sck_prev_q == ckp_q);
    assign trail_edge  = sck_edge & (sck_s == ckp_q);
    assign sample_edge = cph_q ? trail_edge : lead_edge;
    assign shift_edge  = cph_q ? lead_edge : trail_edge;
    assign last_sample = sample_edge & (bit_cnt_q == LAST);

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            ckp_q       <= 1'b0;
            cph_q       <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            ckp_q       <= ckp_d;
            cph_q       <= cph_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Frame FSM: next state, shifting and output pulses
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        ckp_d       = ckp_q;
        cph_d       = cph_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    ckp_d     = CKP;
                    cph_d     = CPH;
                    if (CPH) begin
                        tx_sh_d = TX_DATA;
                        miso_d  = 1'b0;
                    end else begin
                        tx_sh_d = {TX_DATA[DATA_W-2:0], 1'b0};
                        miso_d  = TX_DATA[DATA_W-1];
                    end
                end
            end
            ACTIVE: begin
                if (shift_edge) begin
                    miso_d  = tx_sh_q[DATA_W-1];
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                end
                if (sample_edge) begin
                    rx_sh_d   = {rx_sh_q[SW-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
                if (last_sample) begin
                    rx_data_d  = {rx_sh_q, mosi_s};
                    rx_valid_d = 1'b1;
                    state_d    = cs_rise ? IDLE : DONE;
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MISO      = (state_q != IDLE) & miso_q;
    assign RX_DATA   = rx_data_q;
    assign RX_VALID  = rx_valid_q;
    assign BUSY      = (state_q != IDLE);
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_receptor.sv
// Scoreboard bench for spi_receptor: a master model drives
// frames, a monitor pops expected words on every RX_VALID.
module tb_spi_receptor;
    import spi_pkg::*;

    localparam int HPNS = 80;

    logic        CLK, RESET, CKP, CPH, SCK, CS, MOSI, MISO;
    logic [15:0] TX_DATA, RX_DATA;
    logic        RX_VALID, BUSY, FRAME_ERR;

    int          checks = 0;
    int          passed = 0;
    int          rv_cnt = 0;
    int          ferr_cnt = 0;
    int          nbit = 0;
    logic [15:0] miso_word;
    logic [15:0] exp_q[$];

    spi_receptor #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH),
        .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
        .TX_DATA(TX_DATA), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare each received word against the scoreboard
    always @(negedge CLK) begin
        if (RESET) begin
            if (RX_VALID) begin
                rv_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rx_valid", {16'h0, RX_DATA}, 32'hFFFF_FFFF);
                end else begin
                    chk("rx_data", {16'h0, RX_DATA}, {16'h0, exp_q.pop_front()});
                end
            end
            if (FRAME_ERR) ferr_cnt++;
        end
    end

    task automatic start_frame(input logic [1:0] mode,
                               input logic [15:0] tx, input int pre);
        CKP = mode[1];
        CPH = mode[0];
        SCK = mode[1];
        TX_DATA = tx;
        miso_word = '0;
        nbit = 0;
        #(pre * 10);
        CS = 1'b0;
        #(HPNS);
    endtask

    task automatic xfer_bit(input logic b);
        if (!CPH) begin
            MOSI = b;
            #(HPNS);
            SCK = ~CKP;
            if (nbit < 16) begin
                miso_word = {miso_word[14:0], MISO};
                nbit++;
            end
            #(HPNS);
            SCK = CKP;
        end else begin
            SCK = ~CKP;
            MOSI = b;
            #(HPNS);
            SCK = CKP;
            if (nbit < 16) begin
                miso_word = {miso_word[14:0], MISO};
                nbit++;
            end
            #(HPNS);
        end
    endtask

    task automatic end_frame();
        #(HPNS);
        CS = 1'b1;
        MOSI = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] mode, input logic [15:0] tx,
                             input logic [15:0] rxw, input int nbits,
                             input int pre, input bit expect_rx);
        logic [15:0] sh;
        sh = rxw;
        if (expect_rx) exp_q.push_back(rxw);
        start_frame(mode, tx, pre);
        for (int i = 0; i < nbits; i++) begin
            xfer_bit(sh[15]);
            sh = {sh[14:0], 1'b1};
        end
        end_frame();
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] modes[4];
        int rv0, fe0;
        modes[0] = MODO0;
        modes[1] = MODO1;
        modes[2] = MODO2;
        modes[3] = MODO3;

        RESET = 1'b0; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        CKP = 1'b0; CPH = 1'b0; TX_DATA = '0; miso_word = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs",
            {11'h0, MISO, RX_VALID, BUSY, FRAME_ERR, RX_DATA}, 32'h0);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);

        for (int m = 0; m < 4; m++) begin
            rv0 = rv_cnt;
            run_frame(modes[m], 16'h3C5A, 16'hA5C3, 16, 8, 1'b1);
            #(200);
            chk($sformatf("mode%0d_miso_word", m), {16'h0, miso_word}, 32'h3C5A);
            chk($sformatf("mode%0d_rx_valid_count", m), rv_cnt - rv0, 1);
            chk($sformatf("mode%0d_idle", m), {30'h0, BUSY, MISO}, 32'h0);
        end

        rv0 = rv_cnt;
        fe0 = ferr_cnt;
        run_frame(MODO0, 16'h1111, 16'h5A5A, 9, 8, 1'b0);
        #(200);
        chk("short_frame_err_count", ferr_cnt - fe0, 1);
        chk("short_frame_no_valid", rv_cnt - rv0, 0);
        chk("short_frame_rx_kept", {16'h0, RX_DATA}, 32'hA5C3);
        chk("short_frame_idle", {31'h0, BUSY}, 32'h0);

        rv0 = rv_cnt;
        fe0 = ferr_cnt;
        run_frame(MODO0, 16'h8001, 16'hFFFF, 18, 8, 1'b1);
        #(200);
        chk("long_frame_rx_valid_count", rv_cnt - rv0, 1);
        chk("long_frame_no_err", ferr_cnt - fe0, 0);
        chk("long_frame_rx_data", {16'h0, RX_DATA}, 32'hFFFF);
        chk("long_frame_miso_word", {16'h0, miso_word}, 32'h8001);

        rv0 = rv_cnt;
        fe0 = ferr_cnt;
        start_frame(MODO0, 16'hFFFF, 8);
        for (int i = 0; i < 8; i++) xfer_bit(1'b1);
        chk("mid_frame_busy", {31'h0, BUSY}, 32'h1);
        RESET = 1'b0;
        #1;
        chk("async_reset_outputs",
            {11'h0, MISO, RX_VALID, BUSY, FRAME_ERR, RX_DATA}, 32'h0);
        CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        @(negedge CLK);
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        chk("abort_no_events", (rv_cnt - rv0) + (ferr_cnt - fe0), 0);

        rv0 = rv_cnt;
        run_frame(MODO0, 16'hC003, 16'h0001, 16, 8, 1'b1);
        #(200);
        chk("post_reset_rx_valid_count", rv_cnt - rv0, 1);
        chk("post_reset_rx_data", {16'h0, RX_DATA}, 32'h0001);
        chk("post_reset_miso_word", {16'h0, miso_word}, 32'hC003);

        rv0 = rv_cnt;
        fe0 = ferr_cnt;
        run_frame(MODO0, 16'h5555, 16'h1234, 16, 8, 1'b1);
        chk("b2b_first_miso_word", {16'h0, miso_word}, 32'h5555);
        run_frame(MODO0, 16'hA0F1, 16'hBEEF, 16, 2, 1'b1);
        #(200);
        chk("b2b_second_miso_word", {16'h0, miso_word}, 32'hA0F1);
        chk("b2b_rx_valid_count", rv_cnt - rv0, 2);
        chk("b2b_no_err", ferr_cnt - fe0, 0);
        chk("b2b_last_rx_data", {16'h0, RX_DATA}, 32'hBEEF);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_frame_err_count", ferr_cnt, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
